// File: rtl/rr_mem_controller.sv
// rr_mem_controller: arbitrates NUM_CONSUMERS requesters onto NUM_CHANNELS
// memory channels. Each channel runs its own IDLE / WAITING / RELAYING FSM
// and keeps its own round-robin pointer. A per-consumer claim bit guarantees
// that a consumer is owned by at most one channel at a time.
//
// Handshake semantics (both consumer and memory sides): a requester raises
// valid and holds it, with address/data stable, until it samples the matching
// ready high; the controller then holds ready high until it samples valid low,
// which ends the transaction. Memory ready is a single-cycle acknowledge that
// is only looked at while the channel is waiting for it.
module rr_mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready,
    output logic [NUM_CHANNELS-1:0]            channel_busy
);

    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_READ_WAITING   = 3'd1,
        ST_WRITE_WAITING  = 3'd2,
        ST_READ_RELAYING  = 3'd3,
        ST_WRITE_RELAYING = 3'd4
    } state_t;

    // Per-channel state
    state_t                 state_q   [NUM_CHANNELS];
    state_t                 state_d   [NUM_CHANNELS];
    logic [CW-1:0]          ptr_q     [NUM_CHANNELS];
    logic [CW-1:0]          ptr_d     [NUM_CHANNELS];
    logic [CW-1:0]          owner_q   [NUM_CHANNELS];
    logic [CW-1:0]          owner_d   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   m_rd_addr_q [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   m_rd_addr_d [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   m_wr_addr_q [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   m_wr_addr_d [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   m_wr_data_q [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   m_wr_data_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] mem_read_valid_q, mem_read_valid_d;
    logic [NUM_CHANNELS-1:0] mem_write_valid_q, mem_write_valid_d;
    logic [NUM_CHANNELS-1:0] busy_q, busy_d;

    // Per-consumer state
    logic [NUM_CONSUMERS-1:0] claim_q, claim_d;
    logic [NUM_CONSUMERS-1:0] c_rd_ready_q, c_rd_ready_d;
    logic [NUM_CONSUMERS-1:0] c_wr_ready_q, c_wr_ready_d;
    logic [DATA_BITS-1:0]     c_rd_data_q [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     c_rd_data_d [NUM_CONSUMERS];

    // Unpacked views of the packed buses
    logic [ADDR_BITS-1:0] c_rd_addr  [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0] c_wr_addr  [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] c_wr_data  [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] m_rd_data  [NUM_CHANNELS];

    // Arbitration scratch: claims already taken this cycle, scan result
    logic [NUM_CONSUMERS-1:0] claim_seen;
    logic                     found;
    logic [CW-1:0]            sel;
    logic [CW-1:0]            idx;

    genvar gi;
    for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_cons
        assign c_rd_addr[gi] = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
        assign c_wr_addr[gi] = consumer_write_address[gi*ADDR_BITS +: ADDR_BITS];
        assign c_wr_data[gi] = consumer_write_data[gi*DATA_BITS +: DATA_BITS];
        assign consumer_read_data[gi*DATA_BITS +: DATA_BITS] = c_rd_data_q[gi];
    end

    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
        assign m_rd_data[gi] = mem_read_data[gi*DATA_BITS +: DATA_BITS];
        assign mem_read_address[gi*ADDR_BITS +: ADDR_BITS] = m_rd_addr_q[gi];
        assign mem_write_address[gi*ADDR_BITS +: ADDR_BITS] =
            (WRITE_ENABLE != 0) ? m_wr_addr_q[gi] : '0;
        assign mem_write_data[gi*DATA_BITS +: DATA_BITS] =
            (WRITE_ENABLE != 0) ? m_wr_data_q[gi] : '0;
    end

    assign mem_read_valid       = mem_read_valid_q;
    assign mem_write_valid      = (WRITE_ENABLE != 0) ? mem_write_valid_q : '0;
    assign consumer_read_ready  = c_rd_ready_q;
    assign consumer_write_ready = (WRITE_ENABLE != 0) ? c_wr_ready_q : '0;
    assign channel_busy         = busy_q;

    // Next-state logic: channels evaluated in index order so a grant made by a
    // lower channel blocks that consumer for higher channels in the same cycle.
    // Releases only update claim_d, so a freed consumer is grantable next cycle.
    always_comb begin
        state_d           = state_q;
        ptr_d             = ptr_q;
        owner_d           = owner_q;
        m_rd_addr_d       = m_rd_addr_q;
        m_wr_addr_d       = m_wr_addr_q;
        m_wr_data_d       = m_wr_data_q;
        mem_read_valid_d  = mem_read_valid_q;
        mem_write_valid_d = mem_write_valid_q;
        busy_d            = busy_q;
        claim_d           = claim_q;
        c_rd_ready_d      = c_rd_ready_q;
        c_wr_ready_d      = c_wr_ready_q;
        c_rd_data_d       = c_rd_data_q;
        claim_seen        = claim_q;
        found             = 1'b0;
        sel               = '0;
        idx               = '0;

        for (int c = 0; c < NUM_CHANNELS; c++) begin
            found = 1'b0;
            sel   = '0;
            case (state_q[c])
                ST_IDLE: begin
                    for (int j = 0; j < NUM_CONSUMERS; j++) begin
                        idx = CW'((int'(ptr_q[c]) + j) % NUM_CONSUMERS);
                        if (!found && !claim_seen[idx] &&
                            (consumer_read_valid[idx] ||
                             ((WRITE_ENABLE != 0) && consumer_write_valid[idx]))) begin
                            found = 1'b1;
                            sel   = idx;
                        end
                    end
                    if (found) begin
                        claim_seen[sel] = 1'b1;
                        claim_d[sel]    = 1'b1;
                        owner_d[c]      = sel;
                        ptr_d[c]        = CW'((int'(sel) + 1) % NUM_CONSUMERS);
                        // Read wins over write for the same consumer
                        if (consumer_read_valid[sel]) begin
                            mem_read_valid_d[c] = 1'b1;
                            m_rd_addr_d[c]      = c_rd_addr[sel];
                            state_d[c]          = ST_READ_WAITING;
                        end else begin
                            mem_write_valid_d[c] = 1'b1;
                            m_wr_addr_d[c]       = c_wr_addr[sel];
                            m_wr_data_d[c]       = c_wr_data[sel];
                            state_d[c]           = ST_WRITE_WAITING;
                        end
                    end
                end
                ST_READ_WAITING: begin
                    if (mem_read_ready[c]) begin
                        mem_read_valid_d[c]         = 1'b0;
                        c_rd_ready_d[owner_q[c]]    = 1'b1;
                        c_rd_data_d[owner_q[c]]     = m_rd_data[c];
                        state_d[c]                  = ST_READ_RELAYING;
                    end
                end
                ST_WRITE_WAITING: begin
                    if (mem_write_ready[c]) begin
                        mem_write_valid_d[c]        = 1'b0;
                        c_wr_ready_d[owner_q[c]]    = 1'b1;
                        state_d[c]                  = ST_WRITE_RELAYING;
                    end
                end
                ST_READ_RELAYING: begin
                    if (!consumer_read_valid[owner_q[c]]) begin
                        c_rd_ready_d[owner_q[c]] = 1'b0;
                        claim_d[owner_q[c]]      = 1'b0;
                        state_d[c]               = ST_IDLE;
                    end
                end
                ST_WRITE_RELAYING: begin
                    if (!consumer_write_valid[owner_q[c]]) begin
                        c_wr_ready_d[owner_q[c]] = 1'b0;
                        claim_d[owner_q[c]]      = 1'b0;
                        state_d[c]               = ST_IDLE;
                    end
                end
                default: begin
                    state_d[c] = ST_IDLE;
                end
            endcase
            busy_d[c] = (state_d[c] != ST_IDLE);
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c]     <= ST_IDLE;
                ptr_q[c]       <= '0;
                owner_q[c]     <= '0;
                m_rd_addr_q[c] <= '0;
                m_wr_addr_q[c] <= '0;
                m_wr_data_q[c] <= '0;
            end
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
                c_rd_data_q[k] <= '0;
            end
            mem_read_valid_q  <= '0;
            mem_write_valid_q <= '0;
            busy_q            <= '0;
            claim_q           <= '0;
            c_rd_ready_q      <= '0;
            c_wr_ready_q      <= '0;
        end else begin
            state_q           <= state_d;
            ptr_q             <= ptr_d;
            owner_q           <= owner_d;
            m_rd_addr_q       <= m_rd_addr_d;
            m_wr_addr_q       <= m_wr_addr_d;
            m_wr_data_q       <= m_wr_data_d;
            c_rd_data_q       <= c_rd_data_d;
            mem_read_valid_q  <= mem_read_valid_d;
            mem_write_valid_q <= mem_write_valid_d;
            busy_q            <= busy_d;
            claim_q           <= claim_d;
            c_rd_ready_q      <= c_rd_ready_d;
            c_wr_ready_q      <= c_wr_ready_d;
        end
    end

endmodule

// File: tb/tb_rr_mem_controller.sv
// Testbench for rr_mem_controller. Instance a: 2 channels with writes.
// Instance b: 1 channel, read-only.
module tb_rr_mem_controller;

    localparam int AB = 8;
    localparam int DB = 16;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // Instance a (2 channels, write enabled)
    logic [NC-1:0]    a_rv = '0, a_wv = '0;
    logic [NC-1:0]    a_rr, a_wr;
    logic [NC*AB-1:0] a_ra = '0, a_wa = '0;
    logic [NC*DB-1:0] a_wd = '0;
    logic [NC*DB-1:0] a_rd;
    logic [1:0]       a_mrr = '0, a_mwr = '0;
    logic [2*DB-1:0]  a_mrd = '0;
    logic [1:0]       a_mrv, a_mwv, a_busy;
    logic [2*AB-1:0]  a_mra, a_mwa;
    logic [2*DB-1:0]  a_mwd;

    // Instance b (1 channel, read-only)
    logic [NC-1:0]    b_rv = '0, b_wv = '0;
    logic [NC-1:0]    b_rr, b_wr;
    logic [NC*AB-1:0] b_ra = '0, b_wa = '0;
    logic [NC*DB-1:0] b_wd = '0;
    logic [NC*DB-1:0] b_rd;
    logic [0:0]       b_mrr = '0, b_mwr = '0;
    logic [DB-1:0]    b_mrd = '0;
    logic [0:0]       b_mrv, b_mwv, b_busy;
    logic [AB-1:0]    b_mra, b_mwa;
    logic [DB-1:0]    b_mwd;

    int checks = 0;
    int errors = 0;

    rr_mem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                        .NUM_CHANNELS(2), .WRITE_ENABLE(1)) dut_a (
        .clk(clk), .reset(reset),
        .consumer_read_valid(a_rv), .consumer_read_address(a_ra),
        .consumer_read_ready(a_rr), .consumer_read_data(a_rd),
        .consumer_write_valid(a_wv), .consumer_write_address(a_wa),
        .consumer_write_data(a_wd), .consumer_write_ready(a_wr),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
        .mem_write_data(a_mwd), .mem_write_ready(a_mwr),
        .channel_busy(a_busy)
    );

    rr_mem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                        .NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut_b (
        .clk(clk), .reset(reset),
        .consumer_read_valid(b_rv), .consumer_read_address(b_ra),
        .consumer_read_ready(b_rr), .consumer_read_data(b_rd),
        .consumer_write_valid(b_wv), .consumer_write_address(b_wa),
        .consumer_write_data(b_wd), .consumer_write_ready(b_wr),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
        .mem_write_data(b_mwd), .mem_write_ready(b_mwr),
        .channel_busy(b_busy)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model of instance a: each channel either owns one consumer
    // (owner >= 0) or is free; a consumer is unavailable while any channel
    // owned it at the start of the cycle or a lower channel just took it.
    int              m_owner [2];
    bit              m_is_wr [2];
    bit              m_acked [2];
    int              m_ptr   [2];
    logic [AB-1:0]   m_addr  [2];
    logic [DB-1:0]   m_wdata [2];
    logic [DB-1:0]   m_rdata [NC];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_owner[c] = -1; m_is_wr[c] = 0; m_acked[c] = 0; m_ptr[c] = 0;
            m_addr[c] = '0; m_wdata[c] = '0;
        end
        for (int k = 0; k < NC; k++) m_rdata[k] = '0;
    endtask

    function automatic bit model_ready(int k, bit wr);
        for (int c = 0; c < 2; c++)
            if (m_owner[c] == k && m_is_wr[c] == wr && m_acked[c]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        bit taken [NC];
        for (int k = 0; k < NC; k++) taken[k] = 0;
        for (int c = 0; c < 2; c++) if (m_owner[c] >= 0) taken[m_owner[c]] = 1;
        for (int c = 0; c < 2; c++) begin
            if (m_owner[c] < 0) begin
                for (int j = 0; j < NC; j++) begin
                    int k;
                    k = (m_ptr[c] + j) % NC;
                    if (!taken[k] && (a_rv[k] || a_wv[k])) begin
                        taken[k]   = 1;
                        m_owner[c] = k;
                        m_ptr[c]   = (k + 1) % NC;
                        m_acked[c] = 0;
                        m_is_wr[c] = !a_rv[k];
                        m_addr[c]  = a_rv[k] ? a_ra[k*AB +: AB] : a_wa[k*AB +: AB];
                        m_wdata[c] = a_wd[k*DB +: DB];
                        break;
                    end
                end
            end else if (!m_acked[c]) begin
                if (!m_is_wr[c] && a_mrr[c]) begin
                    m_acked[c] = 1;
                    m_rdata[m_owner[c]] = a_mrd[c*DB +: DB];
                end else if (m_is_wr[c] && a_mwr[c]) begin
                    m_acked[c] = 1;
                end
            end else if (m_is_wr[c] ? !a_wv[m_owner[c]] : !a_rv[m_owner[c]]) begin
                m_owner[c] = -1;
            end
        end
    endtask

    // Driver helpers
    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        a_rv = '0; a_wv = '0; a_mrr = '0; a_mwr = '0;
        b_rv = '0; b_wv = '0; b_mrr = '0; b_mwr = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({a_mrv, a_mwv, a_busy} !== 6'b0) begin errors++; $display("FAIL rst_a_chan got %b exp 0", {a_mrv, a_mwv, a_busy}); end
        checks++; if ({a_rr, a_wr} !== 8'b0) begin errors++; $display("FAIL rst_a_ready got %b exp 0", {a_rr, a_wr}); end
        checks++; if (a_rd !== '0) begin errors++; $display("FAIL rst_a_rdata got %h exp 0", a_rd); end
        checks++; if ({a_mra, a_mwa, a_mwd} !== '0) begin errors++; $display("FAIL rst_a_mem_bus got %h exp 0", {a_mra, a_mwa, a_mwd}); end
        checks++; if ({b_mrv, b_mwv, b_busy, b_rr, b_wr} !== '0) begin errors++; $display("FAIL rst_b_ctrl got %b exp 0", {b_mrv, b_mwv, b_busy, b_rr, b_wr}); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        a_rv[2] = 1'b1; a_ra[23:16] = 8'h3C;
        @(posedge clk); #1;
        checks++; if (a_mrv !== 2'b01) begin errors++; $display("FAIL sr_mem_valid got %b exp 01", a_mrv); end
        checks++; if (a_mra[7:0] !== 8'h3C) begin errors++; $display("FAIL sr_mem_addr got %h exp 3c", a_mra[7:0]); end
        checks++; if (a_busy !== 2'b01) begin errors++; $display("FAIL sr_busy got %b exp 01", a_busy); end
        repeat (2) begin
            @(posedge clk); #1;
            checks++; if ({a_mrv, a_rr} !== 6'b01_0000) begin errors++; $display("FAIL sr_hold got %b exp 010000", {a_mrv, a_rr}); end
        end
        @(negedge clk);
        a_mrr = 2'b01; a_mrd[15:0] = 16'hBEEF;
        @(posedge clk); #1;
        checks++; if (a_rr !== 4'b0100) begin errors++; $display("FAIL sr_ready got %b exp 0100", a_rr); end
        checks++; if (a_rd[47:32] !== 16'hBEEF) begin errors++; $display("FAIL sr_data got %h exp beef", a_rd[47:32]); end
        checks++; if (a_mrv !== 2'b00) begin errors++; $display("FAIL sr_mem_valid_drop got %b exp 00", a_mrv); end
        @(negedge clk);
        a_mrr = 2'b00;
        @(posedge clk); #1;
        checks++; if (a_rr !== 4'b0100) begin errors++; $display("FAIL sr_ready_held got %b exp 0100", a_rr); end
        @(negedge clk);
        a_rv[2] = 1'b0;
        @(posedge clk); #1;
        checks++; if ({a_rr, a_busy} !== 6'b0) begin errors++; $display("FAIL sr_release got %b exp 0", {a_rr, a_busy}); end
    endtask

    task automatic test_multi_channel();
        @(negedge clk);
        a_rv = 4'b0011; a_ra[15:0] = 16'h2211;
        @(posedge clk); #1;
        checks++; if (a_mrv !== 2'b11) begin errors++; $display("FAIL mc_mem_valid got %b exp 11", a_mrv); end
        checks++; if (a_mra !== 16'h2211) begin errors++; $display("FAIL mc_mem_addr got %h exp 2211", a_mra); end
        @(negedge clk);
        a_mrr = 2'b11; a_mrd = 32'h2222_1111;
        @(posedge clk); #1;
        checks++; if (a_rr !== 4'b0011) begin errors++; $display("FAIL mc_ready got %b exp 0011", a_rr); end
        checks++; if (a_rd[31:0] !== 32'h2222_1111) begin errors++; $display("FAIL mc_data got %h exp 22221111", a_rd[31:0]); end
        @(negedge clk);
        a_mrr = 2'b00; a_rv = '0;
        @(posedge clk); #1;
        checks++; if ({a_rr, a_busy} !== 6'b0) begin errors++; $display("FAIL mc_release got %b exp 0", {a_rr, a_busy}); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        a_rv[1] = 1'b1; a_ra[15:8] = 8'h10;
        a_wv[1] = 1'b1; a_wa[15:8] = 8'h20; a_wd[31:16] = 16'h1234;
        @(posedge clk); #1;
        checks++; if ({a_mrv, a_mwv} !== 4'b0100) begin errors++; $display("FAIL pr_read_first got %b exp 0100", {a_mrv, a_mwv}); end
        checks++; if (a_mra[7:0] !== 8'h10) begin errors++; $display("FAIL pr_read_addr got %h exp 10", a_mra[7:0]); end
        @(negedge clk);
        a_mrr = 2'b01; a_mrd[15:0] = 16'h5A5A;
        @(posedge clk); #1;
        checks++; if (a_rr !== 4'b0010) begin errors++; $display("FAIL pr_read_ready got %b exp 0010", a_rr); end
        @(negedge clk);
        a_mrr = 2'b00; a_rv[1] = 1'b0;
        @(posedge clk); #1;
        checks++; if ({a_rr, a_mwv} !== 6'b0) begin errors++; $display("FAIL pr_relay_end got %b exp 0", {a_rr, a_mwv}); end
        @(posedge clk); #1;
        checks++; if (a_mwv !== 2'b01) begin errors++; $display("FAIL pr_write_grant got %b exp 01", a_mwv); end
        checks++; if ({a_mwa[7:0], a_mwd[15:0]} !== 24'h20_1234) begin errors++; $display("FAIL pr_write_bus got %h exp 201234", {a_mwa[7:0], a_mwd[15:0]}); end
        @(negedge clk);
        a_mwr = 2'b01;
        @(posedge clk); #1;
        checks++; if ({a_wr, a_mwv} !== 6'b0010_00) begin errors++; $display("FAIL pr_write_ready got %b exp 001000", {a_wr, a_mwv}); end
        @(negedge clk);
        a_mwr = 2'b00; a_wv[1] = 1'b0;
        @(posedge clk); #1;
        checks++; if ({a_wr, a_busy} !== 6'b0) begin errors++; $display("FAIL pr_release got %b exp 0", {a_wr, a_busy}); end
    endtask

    task automatic test_read_only();
        @(negedge clk);
        b_wv[0] = 1'b1; b_wa[7:0] = 8'h5C; b_wd[15:0] = 16'hA55A;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            b_mwr = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            checks++;
            if ({b_mwv, b_wr, b_busy, b_mwa, b_mwd} !== '0) begin
                errors++;
                $display("FAIL ro_cycle%0d got mwv=%b wr=%b busy=%b mwa=%h mwd=%h exp all 0", i, b_mwv, b_wr, b_busy, b_mwa, b_mwd);
            end
        end
        @(negedge clk);
        b_wv = '0; b_mwr = '0;
    endtask

    task automatic test_fairness();
        int            got_q [$];
        logic [AB-1:0] addr_q [$];
        logic [NC-1:0] prev_rr;
        logic          prev_mrv;
        prev_rr = '0; prev_mrv = 1'b0;
        @(negedge clk);
        b_ra = 32'h4342_4140; b_mrd = 16'hCAFE; b_mrr = 1'b1; b_rv = 4'b1111;
        for (int cyc = 0; cyc < 200 && got_q.size() < 8; cyc++) begin
            @(posedge clk); #1;
            if (b_mrv[0] && !prev_mrv) addr_q.push_back(b_mra);
            for (int k = 0; k < NC; k++) if (b_rr[k] && !prev_rr[k]) got_q.push_back(k);
            prev_rr = b_rr; prev_mrv = b_mrv[0];
            @(negedge clk);
            for (int k = 0; k < NC; k++) begin
                if (b_rv[k] && b_rr[k]) b_rv[k] = 1'b0;
                else if (!b_rv[k] && !b_rr[k]) b_rv[k] = 1'b1;
            end
        end
        checks++; if (got_q.size() < 8) begin errors++; $display("FAIL rr_timeout got %0d grants exp 8", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            checks++; if (got_q[i] !== i % NC) begin errors++; $display("FAIL rr_order%0d got %0d exp %0d", i, got_q[i], i % NC); end
        end
        for (int i = 0; i < addr_q.size() && i < 8; i++) begin
            checks++; if (addr_q[i] !== 8'(8'h40 + i % NC)) begin errors++; $display("FAIL rr_addr%0d got %h exp %h", i, addr_q[i], 8'(8'h40 + i % NC)); end
        end
        @(negedge clk);
        b_rv = '0;
        repeat (4) @(negedge clk);
        b_mrr = 1'b0;
        @(posedge clk); #1;
        checks++; if ({b_busy, b_rr} !== '0) begin errors++; $display("FAIL rr_drain got %b exp 0", {b_busy, b_rr}); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_rv[1] = 1'b1; a_ra[15:8] = 8'h77;
        @(posedge clk); #1;
        checks++; if ({a_mrv, a_mra[7:0]} !== {2'b01, 8'h77}) begin errors++; $display("FAIL rm_grant got %b/%h exp 01/77", a_mrv, a_mra[7:0]); end
        @(negedge clk);
        reset = 1'b1; a_rv = '0;
        @(posedge clk); #1;
        checks++; if ({a_mrv, a_mwv, a_busy, a_rr, a_wr, a_mra} !== '0) begin errors++; $display("FAIL rm_outputs got %h exp 0", {a_mrv, a_mwv, a_busy, a_rr, a_wr, a_mra}); end
        @(negedge clk);
        reset = 1'b0; a_mrr = 2'b01; a_mrd[15:0] = 16'hDEAD;
        @(posedge clk); #1;
        checks++; if ({a_rr, a_mrv, a_busy} !== '0) begin errors++; $display("FAIL rm_ready_ignored got %b exp 0", {a_rr, a_mrv, a_busy}); end
        checks++; if (a_rd[31:16] !== 16'h0) begin errors++; $display("FAIL rm_data_ignored got %h exp 0", a_rd[31:16]); end
        @(negedge clk);
        a_mrr = 2'b00; a_rv = 4'b1111; a_ra = 32'h4433_2211;
        @(posedge clk); #1;
        checks++; if ({a_mrv, a_mra} !== {2'b11, 16'h2211}) begin errors++; $display("FAIL rm_ptr_zero got %b/%h exp 11/2211", a_mrv, a_mra); end
        @(negedge clk);
        a_rv = 4'b0011; a_mrr = 2'b11;
        @(negedge clk);
        a_rv = '0; a_mrr = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0]  e_mrv, e_mwv, e_busy;
        logic [NC-1:0] e_rr, e_wr;
        pulse_reset();
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            // Consumers: drop valid on ready, start new requests only when quiet
            for (int k = 0; k < NC; k++) begin
                bit rr_k, wr_k;
                int mode;
                rr_k = model_ready(k, 1'b0);
                wr_k = model_ready(k, 1'b1);
                if (a_rv[k] && rr_k) a_rv[k] = 1'b0;
                if (a_wv[k] && wr_k) a_wv[k] = 1'b0;
                if (!a_rv[k] && !a_wv[k] && !rr_k && !wr_k && $urandom_range(0, 3) == 0) begin
                    mode = $urandom_range(0, 2);
                    a_ra[k*AB +: AB] = 8'($urandom_range(0, 255));
                    a_wa[k*AB +: AB] = 8'($urandom_range(0, 255));
                    a_wd[k*DB +: DB] = 16'($urandom_range(0, 65535));
                    a_rv[k] = (mode != 1);
                    a_wv[k] = (mode != 0);
                end
            end
            a_mrr = 2'($urandom_range(0, 3));
            a_mwr = 2'($urandom_range(0, 3));
            a_mrd = $urandom;
            @(posedge clk);
            model_step();
            #1;
            for (int c = 0; c < 2; c++) begin
                e_busy[c] = (m_owner[c] >= 0);
                e_mrv[c]  = e_busy[c] && !m_is_wr[c] && !m_acked[c];
                e_mwv[c]  = e_busy[c] && m_is_wr[c] && !m_acked[c];
            end
            for (int k = 0; k < NC; k++) begin
                e_rr[k] = model_ready(k, 1'b0);
                e_wr[k] = model_ready(k, 1'b1);
            end
            checks++; if (a_mrv !== e_mrv) begin errors++; $display("FAIL rnd_mem_rvalid cyc%0d got %b exp %b", cyc, a_mrv, e_mrv); end
            checks++; if (a_mwv !== e_mwv) begin errors++; $display("FAIL rnd_mem_wvalid cyc%0d got %b exp %b", cyc, a_mwv, e_mwv); end
            checks++; if (a_busy !== e_busy) begin errors++; $display("FAIL rnd_busy cyc%0d got %b exp %b", cyc, a_busy, e_busy); end
            checks++; if (a_rr !== e_rr) begin errors++; $display("FAIL rnd_rready cyc%0d got %b exp %b", cyc, a_rr, e_rr); end
            checks++; if (a_wr !== e_wr) begin errors++; $display("FAIL rnd_wready cyc%0d got %b exp %b", cyc, a_wr, e_wr); end
            for (int c = 0; c < 2; c++) begin
                if (e_mrv[c]) begin
                    checks++; if (a_mra[c*AB +: AB] !== m_addr[c]) begin errors++; $display("FAIL rnd_raddr ch%0d cyc%0d got %h exp %h", c, cyc, a_mra[c*AB +: AB], m_addr[c]); end
                end
                if (e_mwv[c]) begin
                    checks++; if ({a_mwa[c*AB +: AB], a_mwd[c*DB +: DB]} !== {m_addr[c], m_wdata[c]}) begin errors++; $display("FAIL rnd_wbus ch%0d cyc%0d got %h/%h exp %h/%h", c, cyc, a_mwa[c*AB +: AB], a_mwd[c*DB +: DB], m_addr[c], m_wdata[c]); end
                end
            end
            for (int k = 0; k < NC; k++) begin
                checks++; if (a_rd[k*DB +: DB] !== m_rdata[k]) begin errors++; $display("FAIL rnd_rdata c%0d cyc%0d got %h exp %h", k, cyc, a_rd[k*DB +: DB], m_rdata[k]); end
            end
            @(negedge clk);
        end
        a_rv = '0; a_wv = '0; a_mrr = '0; a_mwr = '0;
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_single_read();
        test_multi_channel();
        test_priority();
        test_read_only();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
